wide_inv_pipe: RTL and testbench
================================

// Module: wide_inv_pipe
// PURPOSE
//  Parametrised successor to the fixed 32-bit wide inverter: a STAGES-deep registered datapath.
//  Applies one of four per-word bit transforms (invert, pass, XOR-mask, reverse+invert).
//  Uses a valid/ready handshake on both sides, a post-reset init sequence that drives rdy,
//  and a count of delivered words.
//  Sits between a word source and sink in benchmark/FPGA-mapping designs.
// PARAMETERS
//  WIDTH        32  data width in bits (>=2)
//  STAGES       2   pipeline register stages, input to output (>=1)
//  INIT_CYCLES  4   clocks after reset release before rdy rises (>=1)
//  CNT_W        16  width of delivered-word counter
// PORTS
//  clock      in   1       single clock, all logic on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  mode       in   2       transform select, sampled with the word on accept
//  mask       in   WIDTH   XOR mask, sampled with the word on accept
//  in_valid   in   1       upstream word valid
//  in_ready   out  1       block accepts a word this cycle
//  d_in       in   WIDTH   input word
//  out_valid  out  1       d_out holds a valid word
//  out_ready  in   1       downstream accepts d_out this cycle
//  d_out      out  WIDTH   transformed word
//  rdy        out  1       init complete; block operational
//  count      out  CNT_W   words delivered since reset (wraps)
// BEHAVIOUR
//  Reset (rst_n=0, async): all stage valids 0, stage data 0, d_out=0, out_valid=0,
//   in_ready=0, rdy=0, count=0, FSM=INIT, init counter=0. Takes effect immediately.
//  Reset mid-operation: all in-flight words are discarded, with no partial output.
//  FSM INIT: counts clocks after rst_n rises. At INIT_CYCLES it moves to RUN and rdy=1 on that edge.
//  FSM RUN: rdy stays 1 until the next reset. There is no other exit.
//  Accept: a word is accepted on a rising edge when in_valid && in_ready.
//  in_ready = rdy && (stage1 empty || stage1 advances this cycle). It is combinational
//   and never depends on in_valid.
//  Transform is applied when entering stage1, using mode/mask sampled on that edge:
//   00: ~d_in
//   01: d_in
//   10: d_in ^ mask
//   11: ~bitrev(d_in), where bit i of the result = ~d_in[WIDTH-1-i]
//  Stage k advances when it is valid and (stage k+1 is empty or advancing).
//   The last stage advances when out_ready=1.
//   This gives full throughput (one word/clock) with no bubbles while out_ready=1.
//  Latency: a word accepted on edge t appears on d_out/out_valid after edge t+STAGES-1
//   (STAGES=1: visible right after the accept edge).
//  Backpressure: while out_valid=1 && out_ready=0, d_out and out_valid hold stable.
//   Earlier stages fill, and in_ready drops once stage1 is full and cannot advance.
//   Words are never dropped or duplicated.
//  d_out is registered (last stage). It holds its last value when out_valid=0.
//  Ordering: strict FIFO. Capacity = STAGES words.
//  count increments by 1 on each edge with out_valid && out_ready.
//   It wraps from 2^CNT_W-1 to 0 with no saturation or flag.
//  Simultaneous accept and deliver in the same cycle is legal. Occupancy stays unchanged.
//  in_valid while rdy=0 is ignored. The word is not accepted, and the source must hold it.
// TESTING (WIDTH=32, STAGES=2, INIT_CYCLES=4)
//  1. Reset release, in_valid=1 from cycle 0 -> rdy and in_ready stay 0 for 4 clocks,
//     then rise. No word is accepted before then.
//  2. mode=00, d_in sequence ffffffff, ffff0000, 0000ffff, 55555555, out_ready=1 ->
//     d_out sequence 00000000, 0000ffff, ffff0000, aaaaaaaa on consecutive cycles,
//     first word 1 clock after accept.
//  3. mode=10 with mask=0000ffff, d_in=55555555 -> 5555aaaa.
//     mode=11, d_in=00000001 -> 7fffffff.
//     mode=01, d_in=88888888 -> 88888888.
//  4. Stream 6 words with out_ready toggling 1,0,0,1,... -> all 6 words out in order,
//     d_out stable while stalled, in_ready=0 once both stages are full, count ends at 6.
//  5. rst_n pulsed low with 2 words in flight -> out_valid=0 and count=0 immediately.
//     Pre-reset words never appear, and the init sequence repeats.
//  6. CNT_W=4, deliver 17 words -> count reads 1 after wrap (15 -> 0 -> 1).

Source files
------------

// File: rtl/wide_inv_pipe.sv
// Registered word pipeline with per-word bit transform, valid/ready on both sides,
// a post-reset init sequence gating rdy, and a wrapping delivered-word counter.
module wide_inv_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned STAGES      = 2,
  parameter int unsigned INIT_CYCLES = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic             rdy,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned INIT_W = $clog2(INIT_CYCLES + 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [INIT_W-1:0] init_cnt;
  logic [INIT_W-1:0] init_cnt_next;
  logic              rdy_next;

  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [WIDTH-1:0]  stage_in   [STAGES];
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_load;
  logic [STAGES-1:0] advance;
  logic              stage1_open;
  logic              accept;

  function automatic logic [WIDTH-1:0] xform(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] mk
  );
    logic [WIDTH-1:0] r;
    r = d;
    case (m)
      2'b00:   r = ~d;
      2'b01:   r = d;
      2'b10:   r = d ^ mk;
      2'b11: begin
        for (int i = 0; i < int'(WIDTH); i++) begin
          r[i] = ~d[int'(WIDTH) - 1 - i];
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  // Init sequencer: state register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      rdy      <= 1'b0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
      rdy      <= rdy_next;
    end
  end

  // Init sequencer: next state; rdy rises on the INIT_CYCLES-th edge after release
  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    rdy_next      = rdy;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
          state_next    = ST_RUN;
          rdy_next      = 1'b1;
          init_cnt_next = '0;
        end else begin
          init_cnt_next = init_cnt + INIT_W'(1);
        end
      end
      ST_RUN: begin
        rdy_next = 1'b1;
      end
      default: begin
        state_next = ST_INIT;
        rdy_next   = 1'b0;
      end
    endcase
  end

  // A stage can move on iff out_ready or some later stage is empty (bubbles collapse)
  always_comb begin : adv_chain
    logic open_acc;
    open_acc = out_ready;
    advance  = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      advance[k] = stage_valid[k] && open_acc;
      open_acc   = open_acc || !stage_valid[k];
    end
    stage1_open = open_acc;
  end

  assign in_ready = rdy && stage1_open;
  assign accept   = in_valid && in_ready;

  // Per-stage load enable and source word
  always_comb begin
    stage_load    = '0;
    stage_load[0] = accept;
    stage_in[0]   = xform(mode, d_in, mask);
    for (int k = 1; k < int'(STAGES); k++) begin
      stage_load[k] = advance[k-1];
      stage_in[k]   = stage_data[k-1];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        stage_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (stage_load[k]) begin
          stage_valid[k] <= 1'b1;
          stage_data[k]  <= stage_in[k];
        end else if (advance[k]) begin
          stage_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = stage_valid[STAGES-1];
  assign d_out     = stage_data[STAGES-1];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (out_valid && out_ready) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wide_inv_pipe.sv
// Bench for wide_inv_pipe: directed scenarios plus random traffic, checked against
// an in-order queue model with per-word visibility times.
module tb_wide_inv_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned S  = 2;
  localparam int unsigned IC = 4;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = '0;
  logic [W-1:0]  mask = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  d_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  d_out;
  logic          rdy;
  logic [15:0]   count;

  logic          in_ready4;
  logic          out_valid4;
  logic [W-1:0]  d_out4;
  logic          rdy4;
  logic [3:0]    count4;

  wide_inv_pipe #(.WIDTH(W), .STAGES(S), .INIT_CYCLES(IC), .CNT_W(16)) dut (
    .clock(clock), .rst_n(rst_n), .mode(mode), .mask(mask),
    .in_valid(in_valid), .in_ready(in_ready), .d_in(d_in),
    .out_valid(out_valid), .out_ready(out_ready), .d_out(d_out),
    .rdy(rdy), .count(count)
  );

  wide_inv_pipe #(.WIDTH(W), .STAGES(S), .INIT_CYCLES(IC), .CNT_W(4)) dut4 (
    .clock(clock), .rst_n(rst_n), .mode(mode), .mask(mask),
    .in_valid(in_valid), .in_ready(in_ready4), .d_in(d_in),
    .out_valid(out_valid4), .out_ready(out_ready), .d_out(d_out4),
    .rdy(rdy4), .count(count4)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        q[$];
  logic [31:0] got_q[$];
  int          e_cnt = 0;
  int          last_dep = 0;
  logic [31:0] last_out = '0;
  int          dcount = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_xform(input logic [1:0] m, input logic [31:0] d,
                                            input logic [31:0] mk);
    logic [31:0] rev;
    rev = {<<{d}};
    case (m)
      2'b00:   return ~d;
      2'b01:   return d;
      2'b10:   return d ^ mk;
      default: return ~rev;
    endcase
  endfunction

  // Called at a falling edge: drive, check, advance the model across one rising edge
  task automatic cycle(input logic iv, input logic [31:0] d, input logic [1:0] m,
                       input logic [31:0] mk, input logic ordy, output logic acc);
    logic        exp_ov, exp_ir, exp_rdy, dlv;
    logic [31:0] exp_do;
    int          vis;
    in_valid  = iv;
    d_in      = d;
    mode      = m;
    mask      = mk;
    out_ready = ordy;
    #1;
    exp_rdy = (e_cnt >= int'(IC));
    exp_ov  = 1'b0;
    if (q.size() > 0) begin
      vis = q[0].acc + int'(S) - 1;
      if (last_dep > vis) vis = last_dep;
      exp_ov = (vis <= e_cnt);
    end
    exp_do = exp_ov ? q[0].data : last_out;
    exp_ir = exp_rdy && ((q.size() < int'(S)) || (exp_ov && ordy));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("d_out", d_out, exp_do);
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    check("rdy", 32'(rdy), 32'(exp_rdy));
    check("count", 32'(count), 32'(dcount % 65536));
    check("count4", 32'(count4), 32'(dcount % 16));
    acc = iv && exp_ir;
    dlv = exp_ov && ordy;
    if (dlv) got_q.push_back(d_out);
    @(posedge clock);
    e_cnt++;
    if (dlv) begin
      last_out = q[0].data;
      void'(q.pop_front());
      last_dep = e_cnt;
      dcount++;
    end
    if (acc) q.push_back('{data: ref_xform(m, d, mk), acc: e_cnt});
    @(negedge clock);
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases at a falling edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d_out", d_out, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_count4", 32'(count4), 32'd0);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    got_q.delete();
    e_cnt    = 0;
    last_dep = 0;
    last_out = '0;
    dcount   = 0;
    in_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] d, input logic [1:0] m, input logic [31:0] mk);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      cycle(1'b1, d, m, mk, 1'b1, acc);
      n++;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int n);
    logic acc;
    repeat (n) cycle(1'b0, 32'd0, 2'b00, 32'd0, 1'b1, acc);
  endtask

  initial begin
    logic        acc, hv, ordy;
    logic [31:0] hd, hmk;
    logic [1:0]  hm;
    logic [31:0] words [6];
    logic [1:0]  wmodes [6];
    int          sent, k;

    do_reset();

    // Init gating with in_valid held high, then mode 00 streaming
    send(32'hffffffff, 2'b00, 32'd0);
    send(32'hffff0000, 2'b00, 32'd0);
    send(32'h0000ffff, 2'b00, 32'd0);
    send(32'h55555555, 2'b00, 32'd0);
    drain(3);
    check("t2_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      check("t2_w0", got_q[0], 32'h00000000);
      check("t2_w1", got_q[1], 32'h0000ffff);
      check("t2_w2", got_q[2], 32'hffff0000);
      check("t2_w3", got_q[3], 32'haaaaaaaa);
    end

    // Other modes
    got_q.delete();
    send(32'h55555555, 2'b10, 32'h0000ffff);
    send(32'h00000001, 2'b11, 32'h12345678);
    send(32'h88888888, 2'b01, 32'hffffffff);
    drain(3);
    check("t3_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("t3_xor", got_q[0], 32'h5555aaaa);
      check("t3_rev", got_q[1], 32'h7fffffff);
      check("t3_pass", got_q[2], 32'h88888888);
    end

    // Two words in flight, then reset: they must never appear
    cycle(1'b1, 32'hdeadbeef, 2'b01, 32'd0, 1'b0, acc);
    cycle(1'b1, 32'hcafef00d, 2'b01, 32'd0, 1'b0, acc);
    do_reset();

    // Six words under toggling backpressure after the fresh init
    for (int i = 0; i < 6; i++) begin
      words[i]  = $urandom;
      wmodes[i] = 2'($urandom_range(0, 3));
    end
    sent = 0;
    k    = 0;
    while (got_q.size() < 6 && k < 100) begin
      ordy = (k % 3 == 0);
      cycle(sent < 6, words[sent % 6], wmodes[sent % 6], 32'h0f0f0f0f, ordy, acc);
      if (acc) sent++;
      k++;
    end
    check("t4_delivered", 32'(got_q.size()), 32'd6);
    if (got_q.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("t4_order", got_q[i], ref_xform(wmodes[i], words[i], 32'h0f0f0f0f));
      end
    end
    check("t4_final_count", 32'(count), 32'd6);

    // Random traffic; a refused word is held until accepted
    hv = 1'b0;
    hd = '0;
    hm = '0;
    hmk = '0;
    repeat (400) begin
      if (!hv) begin
        hv  = ($urandom_range(0, 3) != 0);
        hd  = $urandom;
        hm  = 2'($urandom_range(0, 3));
        hmk = $urandom;
      end
      cycle(hv, hd, hm, hmk, $urandom_range(0, 2) != 0, acc);
      if (acc) hv = 1'b0;
    end

    // Narrow counter wraps 15 -> 0 -> 1
    do_reset();
    repeat (17) send($urandom, 2'($urandom_range(0, 3)), $urandom);
    drain(3);
    check("t6_count4", 32'(count4), 32'd1);
    check("t6_count", 32'(count), 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
